// File: rtl/alu_inst_encoder_if.sv
// Keypad-to-ALU instruction bus: nibble entry, instruction issue and result handshake.
// The block under the slave modport assembles nibbles into instructions and returns results.
interface alu_inst_encoder_if;
    logic [3:0] nib_in;
    logic       nib_valid;
    logic       nib_ready;
    logic [9:0] inst;
    logic       inst_valid;
    logic [3:0] alu_out;
    logic [3:0] res_data;
    logic       res_valid;
    logic       res_ack;
    logic       op_err;
    logic       mismatch;
    logic [7:0] op_count;

    modport slave (
        input  nib_in, nib_valid, alu_out, res_ack,
        output nib_ready, inst, inst_valid, res_data, res_valid, op_err, mismatch, op_count
    );

    modport master (
        output nib_in, nib_valid, alu_out, res_ack,
        input  nib_ready, inst, inst_valid, res_data, res_valid, op_err, mismatch, op_count
    );
endinterface

// File: rtl/alu_inst_encoder.sv
// Collects opcode/A/B nibbles, issues a 10-bit ALU instruction, captures the ALU result
// and cross-checks it against an internal reference before handing it to the consumer.
module alu_inst_encoder #(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    alu_inst_encoder_if.slave   bus
);

    typedef enum logic [2:0] {
        S_OP    = 3'd0,
        S_A     = 3'd1,
        S_B     = 3'd2,
        S_ISSUE = 3'd3,
        S_CAPT  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t     state_r;
    logic [1:0] opcode_r;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [3:0] res_data_r;
    logic       nib_ready_r;
    logic       inst_valid_r;
    logic       res_valid_r;
    logic       op_err_r;
    logic       mismatch_r;
    logic [7:0] op_count_r;
    logic       accept_s;
    logic [3:0] expected_s;

    function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a | b;
            2'b11:   r = ~a + 4'd1;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    // Handshake qualification and reference result for the current instruction.
    always_comb begin
        accept_s   = bus.nib_valid & nib_ready_r;
        expected_s = alu_ref(opcode_r, a_r, b_r);
    end

    // Instruction-assembly FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_OP;
            opcode_r     <= 2'd0;
            a_r          <= 4'd0;
            b_r          <= 4'd0;
            res_data_r   <= 4'd0;
            nib_ready_r  <= 1'b1;
            inst_valid_r <= 1'b0;
            res_valid_r  <= 1'b0;
            op_err_r     <= 1'b0;
            mismatch_r   <= 1'b0;
            op_count_r   <= 8'd0;
        end else begin
            inst_valid_r <= 1'b0;
            op_err_r     <= 1'b0;
            case (state_r)
                S_OP: begin
                    if (accept_s) begin
                        if (bus.nib_in[3:2] == 2'b00) begin
                            opcode_r <= bus.nib_in[1:0];
                            state_r  <= S_A;
                        end else begin
                            op_err_r <= 1'b1;
                        end
                    end
                end
                S_A: begin
                    if (accept_s) begin
                        a_r     <= bus.nib_in;
                        state_r <= S_B;
                    end
                end
                S_B: begin
                    if (accept_s) begin
                        b_r          <= bus.nib_in;
                        nib_ready_r  <= 1'b0;
                        inst_valid_r <= 1'b1;
                        state_r      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_r <= S_CAPT;
                end
                S_CAPT: begin
                    res_data_r  <= bus.alu_out;
                    res_valid_r <= 1'b1;
                    mismatch_r  <= (bus.alu_out != expected_s) && CHECK_EN;
                    state_r     <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.res_ack) begin
                        res_valid_r <= 1'b0;
                        mismatch_r  <= 1'b0;
                        op_count_r  <= op_count_r + 8'd1;
                        nib_ready_r <= 1'b1;
                        state_r     <= S_OP;
                    end
                end
                default: begin
                    nib_ready_r <= 1'b1;
                    state_r     <= S_OP;
                end
            endcase
        end
    end

    assign bus.nib_ready  = nib_ready_r;
    assign bus.inst       = {opcode_r, a_r, b_r};
    assign bus.inst_valid = inst_valid_r;
    assign bus.res_data   = res_data_r;
    assign bus.res_valid  = res_valid_r;
    assign bus.op_err     = op_err_r;
    assign bus.mismatch   = mismatch_r;
    assign bus.op_count   = op_count_r;

endmodule

// File: tb/tb_alu_inst_encoder.sv
// Directed-plus-random bench for alu_inst_encoder; a checked and an unchecked instance
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_alu_inst_encoder;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   model_count = 0;
    bit   alu_fault = 1'b0;

    always #5 clk = ~clk;

    alu_inst_encoder_if bus1 ();
    alu_inst_encoder_if bus0 ();

    alu_inst_encoder #(.CHECK_EN(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    alu_inst_encoder #(.CHECK_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) % 16;
            1:       return (a - b + 16) % 16;
            2:       return a | b;
            default: return (16 - a) % 16;
        endcase
    endfunction

    assign bus1.alu_out = alu_fault ? 4'h0 : 4'(ref_alu(int'(bus1.inst[9:8]), int'(bus1.inst[7:4]), int'(bus1.inst[3:0])));
    assign bus0.alu_out = alu_fault ? 4'h0 : 4'(ref_alu(int'(bus0.inst[9:8]), int'(bus0.inst[7:4]), int'(bus0.inst[3:0])));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [3:0] n, input logic v, input logic ack);
        bus1.nib_in = n;  bus1.nib_valid = v;  bus1.res_ack = ack;
        bus0.nib_in = n;  bus0.nib_valid = v;  bus0.res_ack = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_inst"},       32'(bus1.inst),       32'h0);
        chk({tag, "_inst_valid"}, 32'(bus1.inst_valid), 32'h0);
        chk({tag, "_res_data"},   32'(bus1.res_data),   32'h0);
        chk({tag, "_res_valid"},  32'(bus1.res_valid),  32'h0);
        chk({tag, "_op_err"},     32'(bus1.op_err),     32'h0);
        chk({tag, "_mismatch"},   32'(bus1.mismatch),   32'h0);
        chk({tag, "_op_count"},   32'(bus1.op_count),   32'h0);
    endtask

    // Full transaction: three nibbles, issue/capture timing, hold window, optional ack.
    task automatic do_op(input int op, input int a, input int b, input int hold, input bit ack_it);
        int exp_res;
        int exp_mm;
        int ideal;
        ideal   = ref_alu(op, a, b);
        exp_res = alu_fault ? 0 : ideal;
        exp_mm  = (exp_res != ideal) ? 1 : 0;
        chk("ready_op", 32'(bus1.nib_ready), 32'h1);
        put(4'(op), 1'b1, 1'b0);  tick();
        chk("op_err_low", 32'(bus1.op_err), 32'h0);
        chk("ready_a", 32'(bus1.nib_ready), 32'h1);
        put(4'(a), 1'b1, 1'b0);   tick();
        put(4'(b), 1'b1, 1'b0);   tick();
        chk("inst", 32'(bus1.inst), 32'(op * 256 + a * 16 + b));
        chk("inst_valid_hi", 32'(bus1.inst_valid), 32'h1);
        chk("ready_issue", 32'(bus1.nib_ready), 32'h0);
        put(4'($urandom), 1'b1, 1'b1);  tick();
        chk("inst_valid_lo", 32'(bus1.inst_valid), 32'h0);
        chk("res_valid_early", 32'(bus1.res_valid), 32'h0);
        put(4'h0, 1'b0, 1'b0);  tick();
        chk("res_valid", 32'(bus1.res_valid), 32'h1);
        chk("res_data", 32'(bus1.res_data), 32'(exp_res));
        chk("mismatch", 32'(bus1.mismatch), 32'(exp_mm));
        chk("res_data_nochk", 32'(bus0.res_data), 32'(exp_res));
        chk("mismatch_nochk", 32'(bus0.mismatch), 32'h0);
        for (int k = 0; k < hold; k++) begin
            put(4'($urandom), 1'b1, 1'b0);  tick();
            chk("hold_valid", 32'(bus1.res_valid), 32'h1);
            chk("hold_data", 32'(bus1.res_data), 32'(exp_res));
            chk("hold_mismatch", 32'(bus1.mismatch), 32'(exp_mm));
            chk("hold_inst", 32'(bus1.inst), 32'(op * 256 + a * 16 + b));
            chk("hold_op_err", 32'(bus1.op_err), 32'h0);
        end
        put(4'h0, 1'b0, 1'b0);
        if (ack_it) begin
            put(4'h0, 1'b0, 1'b1);  tick();
            put(4'h0, 1'b0, 1'b0);
            model_count = (model_count + 1) % 256;
            chk("ack_valid", 32'(bus1.res_valid), 32'h0);
            chk("ack_mismatch", 32'(bus1.mismatch), 32'h0);
            chk("op_count", 32'(bus1.op_count), 32'(model_count));
            chk("op_count_nochk", 32'(bus0.op_count), 32'(model_count));
            chk("ready_after_ack", 32'(bus1.nib_ready), 32'h1);
        end
    endtask

    initial begin
        reset = 1'b1;
        put(4'h0, 1'b0, 1'b0);
        tick();  tick();
        chk_cleared("reset");
        reset = 1'b0;
        chk("ready_after_reset", 32'(bus1.nib_ready), 32'h1);
        tick();

        do_op(0, 5, 3, 0, 1'b1);
        do_op(1, 3, 5, 2, 1'b1);
        do_op(3, 1, int'($urandom_range(0, 15)), 0, 1'b1);

        // Rejected opcode nibble, immediately followed by a valid opcode.
        put(4'h4, 1'b1, 1'b0);  tick();
        chk("op_err_pulse", 32'(bus1.op_err), 32'h1);
        chk("op_err_ready", 32'(bus1.nib_ready), 32'h1);
        do_op(2, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0, 1'b1);

        alu_fault = 1'b1;
        do_op(0, 1, 1, 1, 1'b1);
        alu_fault = 1'b0;

        do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 10, 1'b1);

        // Reset mid-way through S_B.
        put(4'h1, 1'b1, 1'b0);  tick();
        put(4'h7, 1'b1, 1'b0);  tick();
        put(4'h0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_count = 0;
        chk_cleared("rst_sb");
        @(posedge clk);  #1 reset = 1'b0;
        chk("rst_sb_ready", 32'(bus1.nib_ready), 32'h1);
        tick();

        // Reset while a result is held.
        do_op(0, 9, 9, 2, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_cleared("rst_hold");
        @(posedge clk);  #1 reset = 1'b0;
        chk("rst_hold_ready", 32'(bus1.nib_ready), 32'h1);
        tick();

        // 256 random acknowledged operations wrap the counter back to zero.
        for (int i = 0; i < 256; i++) begin
            alu_fault = ($urandom_range(0, 7) == 0);
            do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 2)), 1'b1);
        end
        alu_fault = 1'b0;
        chk("op_count_wrap", 32'(bus1.op_count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "bench time limit reached");
    end
endmodule
